plic_param: RTL
===============

Name: plic_param

Overview:
- Parametrised platform-level interrupt controller; successor to the fixed 4-port controller.
- Arbitrates NUM_SRC interrupt sources by programmable priority and a global threshold.
- Tracks a per-source pending/in-service lifecycle through a claim/complete handshake.
- Sits between peripheral interrupt lines and the CPU external-interrupt input; configured through a simple write port.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- PRIO_W, 3, priority/threshold width in bits; priority 0 means never interrupt.
- ID_W, $clog2(NUM_SRC), width of source IDs (0-based).
- EDGE_MASK, {NUM_SRC{1'b0}}, per-source gateway mode, 1 = rising-edge, 0 = level; only honoured with PLIC_EDGE_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- int_signal  in  NUM_SRC  raw interrupt lines, synchronous to clk
- cfg_we  in  1  config write strobe
- cfg_kind  in  2  0 = priority[cfg_idx], 1 = enable[cfg_idx], 2 = threshold, 3 = ignored
- cfg_idx  in  ID_W  target source
- cfg_data  in  PRIO_W  write data; enable uses bit 0
- claim_req  in  1  one-cycle claim request
- complete_valid  in  1  one-cycle completion strobe
- complete_id  in  ID_W  source being completed
- out_int_pending  out  1  registered: an eligible interrupt exists
- out_int_id  out  ID_W  registered: winning source ID
- out_claim_valid  out  1  registered pulse: claim granted
- out_claim_id  out  ID_W  registered: ID granted by last claim

Behaviour:
- Reset (async, rst_n low) clears all of these to 0: pending, in_service, enable, priority, threshold, edge history, and every output. Deassertion takes effect at the next clk edge.
- Gateway, level sources: at each edge, pending[i] is set if int_signal[i] = 1 and in_service[i] = 0. Pending is not cleared by the line dropping; only a claim clears it.
- Eligibility: eligible[i] = pending[i] & enable[i] & (priority[i] > threshold).
- Arbiter (combinational over current state): picks the eligible source with the highest priority. Ties go to the lowest ID.
- Outputs: out_int_pending and out_int_id are registered from the arbiter result, so there is 1 cycle from a pending change to output. out_int_id holds 0 when nothing is eligible.
- Latency: int_signal rises before edge k; pending is set at edge k; out_int_pending = 1 after edge k+1.
- Claim: claim_req sampled at an edge.
  - If the combinational arbiter has a winner w: pending[w] <= 0, in_service[w] <= 1, out_claim_valid <= 1, out_claim_id <= w.
  - Otherwise: out_claim_valid <= 1 and out_claim_id <= 0 with no state change. This is a spurious claim; software reads pending first.
  - out_claim_valid is high for exactly one cycle per claim_req cycle.
  - Back-to-back claims in consecutive cycles return distinct sources, because the arbiter uses live state, not the registered output.
- Complete: complete_valid with in_service[complete_id] = 1 clears in_service at that edge. Complete of a non-in-service ID, or an ID >= NUM_SRC, is ignored.
- A level line still high after complete re-pends at the next edge.
- Simultaneous events in one cycle:
  - claim + complete of the same ID: complete clears the old in_service and the claim cannot select it, since it is not pending.
  - claim + config write: the claim uses pre-write state.
  - gateway set + claim of the same source: the claim wins and pending ends 0.
- Config writes take effect at the edge. The output reflects them one cycle later.
  - Disabling or raising priority/threshold does not clear pending or in_service.
  - cfg_idx >= NUM_SRC is ignored.

Optional Feature:
- Macro: PLIC_EDGE_EN.
- With PLIC_EDGE_EN:
  - Sources with EDGE_MASK[i] = 1 use an edge gateway that registers the previous int_signal.
  - A rising edge sets pending[i] even while in_service[i] = 1, so one edge is deferred and further edges before claim are dropped.
  - Level-high alone does not re-pend.
- Without PLIC_EDGE_EN:
  - EDGE_MASK is ignored, all sources are level, and no edge-history flops exist.

Test Plan:
- NUM_SRC=4, priorities 3,2,4,1, all enabled, threshold 0, int_signal=4'b1111 -> out_int_pending=1, out_int_id=2 two cycles after assertion.
- Claim, then a claim in the next cycle -> claim IDs 2 then 0. Remaining claims return 1, then 3, then out_claim_id=0 with no state change and out_int_pending=0 (lines held high, no completes).
- Threshold=2 with all sources pending -> only IDs 2 (prio 4) and 0 (prio 3) are ever eligible. Sources 1 and 3 never assert out_int_pending.
- Complete ID 2 while line 2 is still high -> source 2 re-pends next edge and out_int_id returns to 2 one cycle later. Complete of a non-in-service ID 3 -> no change.
- Equal priorities 5,5 on IDs 1 and 3 -> ID 1 wins. Disable 1 -> ID 3 wins after one cycle.
- PLIC_EDGE_EN, EDGE_MASK=4'b0001: two pulses on source 0 while in service -> exactly one re-pend after complete. Assert rst_n low mid-claim -> all outputs 0 immediately.

Source files
------------

// File: rtl/plic_param_if.sv
// -----------------------------------------------------------------------------
// plic_param_if
// Bus interface for the parametrised PLIC. It groups the configuration write
// port, the claim/complete handshake and the registered status outputs.
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   cfg_we          in   config write strobe
//   cfg_kind        in   0 = priority, 1 = enable, 2 = threshold, 3 = ignored
//   cfg_idx         in   target source ID
//   cfg_data        in   write data; enable uses bit 0
//   claim_req       in   one-cycle claim request
//   complete_valid  in   one-cycle completion strobe
//   complete_id     in   source being completed
//   out_int_pending out  an eligible interrupt exists
//   out_int_id      out  winning source ID
//   out_claim_valid out  one-cycle claim grant pulse
//   out_claim_id    out  ID granted by the last claim
//
// Modports: master = CPU / configuration side, slave = controller.
// -----------------------------------------------------------------------------
interface plic_param_if #(
  parameter int ID_W   = 3,
  parameter int PRIO_W = 3
);
  logic              cfg_we;
  logic [1:0]        cfg_kind;
  logic [ID_W-1:0]   cfg_idx;
  logic [PRIO_W-1:0] cfg_data;
  logic              claim_req;
  logic              complete_valid;
  logic [ID_W-1:0]   complete_id;
  logic              out_int_pending;
  logic [ID_W-1:0]   out_int_id;
  logic              out_claim_valid;
  logic [ID_W-1:0]   out_claim_id;

  modport master (
    output cfg_we, cfg_kind, cfg_idx, cfg_data,
    output claim_req, complete_valid, complete_id,
    input  out_int_pending, out_int_id, out_claim_valid, out_claim_id
  );

  modport slave (
    input  cfg_we, cfg_kind, cfg_idx, cfg_data,
    input  claim_req, complete_valid, complete_id,
    output out_int_pending, out_int_id, out_claim_valid, out_claim_id
  );
endinterface

// File: rtl/plic_param.sv
// -----------------------------------------------------------------------------
// plic_param
// Parametrised platform-level interrupt controller. NUM_SRC interrupt lines
// pass through a gateway into a pending register; the highest-priority
// pending, enabled source whose priority exceeds the global threshold is
// reported to the CPU. A claim moves the winner from pending to in-service,
// a complete releases it again.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   int_signal  raw interrupt lines, synchronous to clk
//   bus         plic_param_if.slave: config port, claim/complete, outputs
//
// Optional feature (macro PLIC_EDGE_EN): sources with EDGE_MASK[i] = 1 use a
// rising-edge gateway with an edge-history flop. Without the macro every
// source is level-sensitive and EDGE_MASK has no effect.
// -----------------------------------------------------------------------------
module plic_param #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 PRIO_W    = 3,
  parameter int                 ID_W      = $clog2(NUM_SRC),
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] int_signal,
  plic_param_if.slave        bus
);

  localparam logic [1:0] KIND_PRIO   = 2'd0;
  localparam logic [1:0] KIND_ENABLE = 2'd1;
  localparam logic [1:0] KIND_THRESH = 2'd2;

  // Elaboration-time sanity check of the configuration.
  if (NUM_SRC < 2 || NUM_SRC > 32 || $bits(EDGE_MASK) != NUM_SRC) begin : g_bad_param
    $error("plic_param: NUM_SRC must be 2..32 and EDGE_MASK NUM_SRC bits wide");
  end

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [PRIO_W-1:0]  threshold;

  logic [NUM_SRC-1:0] gate_set;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] cpl_clr;
  logic [NUM_SRC-1:0] cfg_hit;
  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;

  // ---------------------------------------------------------------------------
  // Gateway
  // ---------------------------------------------------------------------------
`ifdef PLIC_EDGE_EN
  logic [NUM_SRC-1:0] int_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_prev <= '0;
    else        int_prev <= int_signal;
  end

  // Edge sources pend on a rising edge even while in service, so one edge can
  // be deferred; a level held high does not re-pend them.
  assign gate_set = (int_signal & ~in_service & ~EDGE_MASK)
                  | (int_signal & ~int_prev   &  EDGE_MASK);
`else
  assign gate_set = int_signal & ~in_service;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter over live state: highest priority wins, strict '>' keeps the
  // lowest ID on ties. Using live state (not the registered output) lets
  // back-to-back claims return distinct sources.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    found    = 1'b0;
    win_id   = '0;
    win_prio = '0;
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & enable[i] & (prio[i] > threshold);
      if (eligible[i] && (!found || prio[i] > win_prio)) begin
        found    = 1'b1;
        win_id   = ID_W'(i);
        win_prio = prio[i];
      end
    end
  end

  // Per-source decode of claim, complete and config targets. IDs that match
  // no source (>= NUM_SRC) simply produce no hit and are ignored.
  always_comb begin
    claim_clr = '0;
    cpl_clr   = '0;
    cfg_hit   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = bus.claim_req & found & (win_id == ID_W'(i));
      cpl_clr[i]   = bus.complete_valid & in_service[i] & (bus.complete_id == ID_W'(i));
      cfg_hit[i]   = bus.cfg_we & (bus.cfg_idx == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every update sees pre-edge
  // values; a claim and a config write in one cycle thus use pre-write state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending             <= '0;
      in_service          <= '0;
      enable              <= '0;
      threshold           <= '0;
      // NOTE: the priority array is a small register file, not a RAM, so it
      // is reset along with everything else.
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      bus.out_int_pending <= 1'b0;
      bus.out_int_id      <= '0;
      bus.out_claim_valid <= 1'b0;
      bus.out_claim_id    <= '0;
    end else begin
      // A claim beats a same-cycle gateway set; a claim of an edge source
      // still in service keeps it in service.
      pending    <= (pending | gate_set) & ~claim_clr;
      in_service <= (in_service & ~cpl_clr) | claim_clr;

      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_hit[i] && bus.cfg_kind == KIND_PRIO)   prio[i]   <= bus.cfg_data;
        if (cfg_hit[i] && bus.cfg_kind == KIND_ENABLE) enable[i] <= bus.cfg_data[0];
      end
      if (bus.cfg_we && bus.cfg_kind == KIND_THRESH) threshold <= bus.cfg_data;

      bus.out_int_pending <= found;
      bus.out_int_id      <= found ? win_id : '0;
      bus.out_claim_valid <= bus.claim_req;
      // A claim with no winner is spurious and reports ID 0.
      if (bus.claim_req) bus.out_claim_id <= found ? win_id : '0;
    end
  end

endmodule
